// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between CPU data port, DMA master and the data memory.
// The arbiter takes the slave view; the CPU/DMA/memory side takes the master view.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] data_address;
  logic              data_read;
  logic              data_write;
  logic [DATA_W-1:0] data_writedata;
  logic [DATA_W-1:0] data_readdata;

  logic [ADDR_W-1:0] dma_address;
  logic              dma_read;
  logic              dma_write;
  logic [DATA_W-1:0] dma_writedata;
  logic              dma_waitrequest;
  logic [DATA_W-1:0] dma_readdata;
  logic              dma_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  data_address, data_read, data_write, data_writedata,
    output data_readdata,
    input  dma_address, dma_read, dma_write, dma_writedata,
    output dma_waitrequest, dma_readdata, dma_readdatavalid,
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_readdata
  );

  modport master (
    output data_address, data_read, data_write, data_writedata,
    input  data_readdata,
    output dma_address, dma_read, dma_write, dma_writedata,
    input  dma_waitrequest, dma_readdata, dma_readdatavalid,
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_readdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-way arbiter sharing one data memory between the CPU data port and a DMA
// master. Writes finish in the grant cycle; reads hold one wait cycle for data.
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_enable_in,
  output logic cpu_clk_enable,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_CPU, WAIT_DMA} state_t;
  typedef enum logic {GNT_CPU, GNT_DMA} grant_t;

  state_t state, nxt_state;
  grant_t last_grant, nxt_grant;

  logic cpu_pend, cpu_req, dma_req;
  logic grant_cpu, grant_dma;

  // A stalled CPU keeps its request up; it is only serviceable when enabled.
  assign cpu_pend = bus.data_read | bus.data_write;
  assign cpu_req  = clk_enable_in & cpu_pend;
  assign dma_req  = bus.dma_read | bus.dma_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= GNT_DMA;
    end else begin
      state      <= nxt_state;
      last_grant <= nxt_grant;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_grant = last_grant;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    // Grants are gated by reset so the memory strobes drop the moment reset asserts.
    if (state == IDLE && reset) begin
      grant_cpu = cpu_req && (!dma_req || last_grant == GNT_DMA);
      grant_dma = dma_req && !grant_cpu;
    end
    case (state)
      IDLE: begin
        if (grant_cpu) begin
          nxt_grant = GNT_CPU;
          if (bus.data_read) nxt_state = WAIT_CPU;
        end else if (grant_dma) begin
          nxt_grant = GNT_DMA;
          if (bus.dma_read) nxt_state = WAIT_DMA;
        end
      end
      WAIT_CPU, WAIT_DMA: nxt_state = IDLE;
      default:            nxt_state = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_address       = {ADDR_W{1'b0}};
    bus.mem_writedata     = {DATA_W{1'b0}};
    bus.mem_read          = 1'b0;
    bus.mem_write         = 1'b0;
    bus.data_readdata     = {DATA_W{1'b0}};
    bus.dma_readdata      = {DATA_W{1'b0}};
    bus.dma_readdatavalid = 1'b0;
    bus.dma_waitrequest   = !grant_dma;
    cpu_clk_enable        = 1'b0;

    // Read wins when a requester raises read and write together.
    if (grant_cpu) begin
      bus.mem_address   = bus.data_address;
      bus.mem_writedata = bus.data_writedata;
      bus.mem_read      = bus.data_read;
      bus.mem_write     = bus.data_write & ~bus.data_read;
    end else if (grant_dma) begin
      bus.mem_address   = bus.dma_address;
      bus.mem_writedata = bus.dma_writedata;
      bus.mem_read      = bus.dma_read;
      bus.mem_write     = bus.dma_write & ~bus.dma_read;
    end

    if (reset) begin
      case (state)
        IDLE: begin
          if (!cpu_pend)                       cpu_clk_enable = clk_enable_in;
          else if (grant_cpu && !bus.data_read) cpu_clk_enable = clk_enable_in;
        end
        WAIT_CPU: begin
          bus.data_readdata = bus.mem_readdata;
          cpu_clk_enable    = clk_enable_in;
        end
        WAIT_DMA: begin
          bus.dma_readdata      = bus.mem_readdata;
          bus.dma_readdatavalid = 1'b1;
          cpu_clk_enable        = cpu_pend ? 1'b0 : clk_enable_in;
        end
        default: cpu_clk_enable = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a one-cycle-latency memory model.
module tb_data_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic clk_enable_in;
  logic cpu_clk_enable;
  int   total = 0;
  int   bad   = 0;

  data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable_in  (clk_enable_in),
    .cpu_clk_enable (cpu_clk_enable),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Data memory: write on the edge, registered read data one cycle after mem_read.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_address[9:2]] <= bus.mem_writedata;
    if (bus.mem_read)  bus.mem_readdata <= mem[bus.mem_address[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.mem_readdata   = 32'h0;
    reset              = 1'b0;
    clk_enable_in      = 1'b1;
    bus.data_address   = 32'h10;
    bus.data_read      = 1'b1;
    bus.data_write     = 1'b0;
    bus.data_writedata = 32'h0;
    bus.dma_address    = 32'h8;
    bus.dma_read       = 1'b1;
    bus.dma_write      = 1'b0;
    bus.dma_writedata  = 32'h0;

    // Reset holds everything quiet even with requests raised
    tick(); settle();
    chk("rst_mem_read",   bus.mem_read, 0);
    chk("rst_mem_write",  bus.mem_write, 0);
    chk("rst_waitreq",    bus.dma_waitrequest, 1);
    chk("rst_cpu_ce",     cpu_clk_enable, 0);
    chk("rst_rvalid",     bus.dma_readdatavalid, 0);
    chk("rst_data_rd",    bus.data_readdata, 0);
    chk("rst_dma_rd",     bus.dma_readdata, 0);

    tick(); reset = 1'b1; bus.data_read = 1'b0; bus.dma_read = 1'b0; settle();
    chk("idle_cpu_ce",    cpu_clk_enable, 1);
    chk("idle_waitreq",   bus.dma_waitrequest, 1);

    // CPU write alone
    tick(); bus.data_write = 1'b1; bus.data_writedata = 32'h20; settle();
    chk("cw_mem_write",   bus.mem_write, 1);
    chk("cw_mem_read",    bus.mem_read, 0);
    chk("cw_addr",        bus.mem_address, 32'h10);
    chk("cw_wdata",       bus.mem_writedata, 32'h20);
    chk("cw_cpu_ce",      cpu_clk_enable, 1);

    // CPU read alone of the same word
    tick(); bus.data_write = 1'b0; bus.data_read = 1'b1; settle();
    chk("cr_mem_read",    bus.mem_read, 1);
    chk("cr_addr",        bus.mem_address, 32'h10);
    chk("cr_cpu_ce",      cpu_clk_enable, 0);
    tick(); settle();
    chk("cr_wait_mrd",    bus.mem_read, 0);
    chk("cr_rdata",       bus.data_readdata, 32'h20);
    chk("cr_wait_ce",     cpu_clk_enable, 1);
    tick(); bus.data_read = 1'b0; settle();
    chk("cr_done_mrd",    bus.mem_read, 0);

    // DMA back-to-back writes
    tick(); bus.dma_write = 1'b1; bus.dma_address = 32'h4; bus.dma_writedata = 32'hA1; settle();
    chk("dw0_waitreq",    bus.dma_waitrequest, 0);
    chk("dw0_mem_write",  bus.mem_write, 1);
    chk("dw0_addr",       bus.mem_address, 32'h4);
    tick(); bus.dma_address = 32'h8; bus.dma_writedata = 32'hA2; settle();
    chk("dw1_waitreq",    bus.dma_waitrequest, 0);
    chk("dw1_mem_write",  bus.mem_write, 1);
    chk("dw1_wdata",      bus.mem_writedata, 32'hA2);
    tick(); bus.dma_address = 32'hC; bus.dma_writedata = 32'hA3; settle();
    chk("dw2_waitreq",    bus.dma_waitrequest, 0);
    chk("dw2_mem_write",  bus.mem_write, 1);
    tick(); bus.dma_write = 1'b0; settle();
    chk("dw_end_waitreq", bus.dma_waitrequest, 1);
    chk("dw_end_mwr",     bus.mem_write, 0);

    // Simultaneous reads: DMA granted last, so CPU wins the tie
    tick(); bus.data_read = 1'b1; bus.data_address = 32'h10;
    bus.dma_read = 1'b1; bus.dma_address = 32'h8; settle();
    chk("tie_mem_read",   bus.mem_read, 1);
    chk("tie_addr_cpu",   bus.mem_address, 32'h10);
    chk("tie_waitreq",    bus.dma_waitrequest, 1);
    chk("tie_cpu_ce",     cpu_clk_enable, 0);
    tick(); settle();
    chk("tie_wc_mrd",     bus.mem_read, 0);
    chk("tie_wc_rdata",   bus.data_readdata, 32'h20);
    chk("tie_wc_waitreq", bus.dma_waitrequest, 1);
    tick(); bus.data_read = 1'b0; settle();
    chk("tie_dma_mrd",    bus.mem_read, 1);
    chk("tie_dma_addr",   bus.mem_address, 32'h8);
    chk("tie_dma_wreq",   bus.dma_waitrequest, 0);
    tick(); bus.dma_read = 1'b0; settle();
    chk("tie_rvalid",     bus.dma_readdatavalid, 1);
    chk("tie_dma_rdata",  bus.dma_readdata, 32'hA2);
    tick(); settle();
    chk("tie_rvalid_off", bus.dma_readdatavalid, 0);

    // Reset during WAIT_DMA discards the read
    tick(); bus.dma_read = 1'b1; bus.dma_address = 32'hC; settle();
    chk("rw_grant",       bus.dma_waitrequest, 0);
    tick(); bus.dma_read = 1'b0; settle();
    chk("rw_rvalid_pre",  bus.dma_readdatavalid, 1);
    reset = 1'b0; #1;
    chk("rw_rvalid_rst",  bus.dma_readdatavalid, 0);
    chk("rw_rdata_rst",   bus.dma_readdata, 0);
    chk("rw_wreq_rst",    bus.dma_waitrequest, 1);
    chk("rw_ce_rst",      cpu_clk_enable, 0);
    tick(); reset = 1'b1; settle();
    chk("rw_rvalid_rel",  bus.dma_readdatavalid, 0);
    tick(); settle();
    chk("rw_rvalid_rel2", bus.dma_readdatavalid, 0);

    // CPU read held off while the system clock enable is low
    tick(); clk_enable_in = 1'b0; bus.data_read = 1'b1; bus.data_address = 32'h10; settle();
    chk("ce0_mem_read",   bus.mem_read, 0);
    chk("ce0_cpu_ce",     cpu_clk_enable, 0);
    tick(); settle();
    chk("ce0_mem_read2",  bus.mem_read, 0);
    chk("ce0_cpu_ce2",    cpu_clk_enable, 0);
    tick(); clk_enable_in = 1'b1; settle();
    chk("ce1_mem_read",   bus.mem_read, 1);
    chk("ce1_cpu_ce",     cpu_clk_enable, 0);
    tick(); settle();
    chk("ce1_rdata",      bus.data_readdata, 32'h20);
    chk("ce1_wait_ce",    cpu_clk_enable, 1);

    // Write tie after a CPU grant: DMA wins, CPU stalls one cycle
    tick(); bus.data_read = 1'b0; bus.data_write = 1'b1; bus.data_address = 32'h20;
    bus.data_writedata = 32'h55; bus.dma_write = 1'b1; bus.dma_address = 32'h24;
    bus.dma_writedata = 32'h66; settle();
    chk("wt_addr_dma",    bus.mem_address, 32'h24);
    chk("wt_waitreq",     bus.dma_waitrequest, 0);
    chk("wt_cpu_ce",      cpu_clk_enable, 0);
    tick(); bus.dma_write = 1'b0; settle();
    chk("wt_addr_cpu",    bus.mem_address, 32'h20);
    chk("wt_mem_write",   bus.mem_write, 1);
    chk("wt_cpu_ce2",     cpu_clk_enable, 1);
    tick(); bus.data_write = 1'b0; settle();
    chk("wt_mem_20",      mem[8], 32'h55);
    chk("wt_mem_24",      mem[9], 32'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
